// File: rtl/disparity_stream_framer.sv
// Frames a raw disparity/confidence/gray pixel stream into lines and frames,
// tagging line/frame boundaries and enforcing an idle flush gap between frames.
module disparity_stream_framer #(
    parameter int disp_bits    = 5,
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [disp_bits-1:0] pix_disparity,
    input  logic [7:0]           pix_confidence,
    input  logic [7:0]           pix_gray,
    input  logic                 pix_sof,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [disp_bits-1:0] disparity_out,
    output logic [7:0]           confidence_out,
    output logic [7:0]           gray_out,
    output logic                 first_pixel_in_line,
    output logic                 last_pixel_in_line,
    output logic                 last_pixel_in_frame,
    output logic                 out_valid,
    output logic                 frame_error,
    output logic [15:0]          frames_done
);
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, FLUSH} state_t;

    localparam logic [9:0] LAST_COL   = 10'(LINE_WIDTH - 1);
    localparam logic [9:0] LAST_ROW   = 10'(FRAME_HEIGHT - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t               state_q, state_d;
    logic [9:0]           col_q, col_d, row_q, row_d;
    logic [3:0]           flush_q, flush_d;
    logic [15:0]          frames_q, frames_d;
    logic [disp_bits-1:0] disp_q;
    logic [7:0]           conf_q, gray_q;
    logic                 first_q, last_line_q, last_frame_q, valid_q, err_q;

    logic       xfer, emit, restart, err;
    logic [9:0] pos_col, pos_row;
    logic       first_d, last_line_d, last_frame_d;

    assign pix_ready = (state_q != FLUSH);
    assign xfer      = pix_valid && pix_ready;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        flush_d  = flush_q;
        frames_d = frames_q;
        emit     = 1'b0;
        restart  = 1'b0;
        err      = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                if (xfer && pix_sof) begin
                    emit    = 1'b1;
                    restart = 1'b1;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    emit    = 1'b1;
                    restart = pix_sof;
                    err     = pix_sof && ((col_q != 10'd0) || (row_q != 10'd0));
                end
            end
            FLUSH: begin
                flush_d = flush_q - 4'd1;
                if (flush_q <= 4'd1) state_d = WAIT_SOF;
            end
            default: state_d = WAIT_SOF;
        endcase

        // A start-of-frame always re-anchors the pixel at (0,0), even mid-frame.
        pos_col      = restart ? 10'd0 : col_q;
        pos_row      = restart ? 10'd0 : row_q;
        first_d      = emit && (pos_col == 10'd0);
        last_line_d  = emit && (pos_col == LAST_COL);
        last_frame_d = last_line_d && (pos_row == LAST_ROW);

        if (emit) begin
            if (last_frame_d) begin
                frames_d = frames_q + 16'd1;
                col_d    = 10'd0;
                row_d    = 10'd0;
                flush_d  = FLUSH_LOAD;
                state_d  = FLUSH;
            end else begin
                state_d = ACTIVE;
                if (pos_col == LAST_COL) begin
                    col_d = 10'd0;
                    row_d = pos_row + 10'd1;
                end else begin
                    col_d = pos_col + 10'd1;
                    row_d = pos_row;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SOF;
            col_q        <= '0;
            row_q        <= '0;
            flush_q      <= '0;
            frames_q     <= '0;
            disp_q       <= '0;
            conf_q       <= '0;
            gray_q       <= '0;
            first_q      <= 1'b0;
            last_line_q  <= 1'b0;
            last_frame_q <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            flush_q      <= flush_d;
            frames_q     <= frames_d;
            first_q      <= first_d;
            last_line_q  <= last_line_d;
            last_frame_q <= last_frame_d;
            valid_q      <= emit;
            err_q        <= err;
            if (emit) begin
                disp_q <= pix_disparity;
                conf_q <= pix_confidence;
                gray_q <= pix_gray;
            end
        end
    end

    assign disparity_out       = disp_q;
    assign confidence_out      = conf_q;
    assign gray_out            = gray_q;
    assign first_pixel_in_line = first_q;
    assign last_pixel_in_line  = last_line_q;
    assign last_pixel_in_frame = last_frame_q;
    assign out_valid           = valid_q;
    assign frame_error         = err_q;
    assign frames_done         = frames_q;
endmodule
